// File: rtl/spi_ss_sequencer.sv
// Round-robin slave-select sequencer: shares one single-SS SPI master among NUM_SS
// clients and enforces select setup, hold, inter-frame gap and transfer timeout.
module spi_ss_sequencer #(
    parameter int NUM_SS      = 5,
    parameter int CMD_W       = 16,
    parameter int SETUP_CYC   = 2,
    parameter int GAP_CYC     = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SS-1:0]         req,
    input  logic [NUM_SS*CMD_W-1:0]   cmd_in,
    output logic [NUM_SS-1:0]         ack,
    output logic [NUM_SS-1:0]         err,
    output logic [CMD_W-1:0]          rd_data,
    output logic [CMD_W-1:0]          SPI_cmd,
    output logic                      wrt_SPI,
    input  logic                      SPI_done,
    input  logic [CMD_W-1:0]          SPI_data_out,
    output logic [NUM_SS-1:0]         ss_n,
    output logic                      busy
);

    localparam int IDX_W = $clog2(NUM_SS);
    localparam int SET_W = $clog2(SETUP_CYC + 1);
    localparam int GAP_W = $clog2(GAP_CYC + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [SET_W-1:0]  SET_LAST = SET_W'(SETUP_CYC - 1);
    localparam logic [SET_W-1:0]  SET_INC  = SET_W'(1);
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYC - 1);
    localparam logic [GAP_W-1:0]  GAP_INC  = GAP_W'(1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [TMO_W-1:0]  TMO_INC  = TMO_W'(1);
    localparam logic [NUM_SS-1:0] SS_ONE   = {{(NUM_SS-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_XFER  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [SET_W-1:0]    setup_cnt_q, setup_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic [NUM_SS-1:0]   ss_n_q, ss_n_d;
    logic [NUM_SS-1:0]   ack_q, ack_d;
    logic [NUM_SS-1:0]   err_q, err_d;
    logic                wrt_q, wrt_d;
    logic                busy_q, busy_d;
    logic [CMD_W-1:0]    cmd_q, cmd_d;
    logic [CMD_W-1:0]    rd_q, rd_d;
    logic                grant_vld_s;
    logic [IDX_W-1:0]    grant_idx_s;

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_SS) begin
            sum = sum - NUM_SS;
        end else begin
            sum = sum;
        end
        return IDX_W'(sum);
    endfunction

    // Round-robin pick: scanning from the far end lets the nearest requester win.
    always_comb begin
        grant_vld_s = |req;
        grant_idx_s = rr_ptr_q;
        for (int j = NUM_SS - 1; j >= 0; j--) begin
            grant_idx_s = req[wrap_add(rr_ptr_q, j)] ? wrap_add(rr_ptr_q, j) : grant_idx_s;
        end
    end

    // Frame sequencing and next values of every registered output.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        rr_ptr_d    = rr_ptr_q;
        setup_cnt_d = setup_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        ss_n_d      = ss_n_q;
        ack_d       = {NUM_SS{1'b0}};
        err_d       = {NUM_SS{1'b0}};
        wrt_d       = 1'b0;
        cmd_d       = cmd_q;
        rd_d        = rd_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_vld_s) begin
                    state_d     = ST_SETUP;
                    idx_d       = grant_idx_s;
                    rr_ptr_d    = wrap_add(grant_idx_s, 1);
                    cmd_d       = cmd_in[int'(grant_idx_s)*CMD_W +: CMD_W];
                    ss_n_d      = ~(SS_ONE << grant_idx_s);
                    setup_cnt_d = {SET_W{1'b0}};
                end else begin
                    ss_n_d = {NUM_SS{1'b1}};
                end
            end
            ST_SETUP: begin
                if (setup_cnt_q == SET_LAST) begin
                    state_d   = ST_XFER;
                    wrt_d     = 1'b1;
                    tmo_cnt_d = {TMO_W{1'b0}};
                end else begin
                    setup_cnt_d = setup_cnt_q + SET_INC;
                end
            end
            ST_XFER: begin
                // A done arriving on the timeout cycle still counts as success.
                if (SPI_done) begin
                    rd_d    = SPI_data_out;
                    ack_d   = SS_ONE << idx_q;
                    state_d = ST_HOLD;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    err_d   = SS_ONE << idx_q;
                    state_d = ST_HOLD;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_INC;
                end
            end
            ST_HOLD: begin
                ss_n_d    = {NUM_SS{1'b1}};
                gap_cnt_d = {GAP_W{1'b0}};
                state_d   = ST_GAP;
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_INC;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ss_n_d  = {NUM_SS{1'b1}};
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= {IDX_W{1'b0}};
            rr_ptr_q    <= {IDX_W{1'b0}};
            setup_cnt_q <= {SET_W{1'b0}};
            gap_cnt_q   <= {GAP_W{1'b0}};
            tmo_cnt_q   <= {TMO_W{1'b0}};
            ss_n_q      <= {NUM_SS{1'b1}};
            ack_q       <= {NUM_SS{1'b0}};
            err_q       <= {NUM_SS{1'b0}};
            wrt_q       <= 1'b0;
            busy_q      <= 1'b0;
            cmd_q       <= {CMD_W{1'b0}};
            rd_q        <= {CMD_W{1'b0}};
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rr_ptr_q    <= rr_ptr_d;
            setup_cnt_q <= setup_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            ss_n_q      <= ss_n_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            wrt_q       <= wrt_d;
            busy_q      <= busy_d;
            cmd_q       <= cmd_d;
            rd_q        <= rd_d;
        end
    end

    assign ack     = ack_q;
    assign err     = err_q;
    assign rd_data = rd_q;
    assign SPI_cmd = cmd_q;
    assign wrt_SPI = wrt_q;
    assign ss_n    = ss_n_q;
    assign busy    = busy_q;

endmodule
